// File: rtl/flash_arb_pkg.sv
// flash_arb_pkg: shared state encoding and owner codes for the flash bus arbiter
package flash_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SOC  = 2'b01,
    ST_HK   = 2'b10,
    ST_GAP  = 2'b11
  } state_t;
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_SOC  = 2'b01;
  localparam logic [1:0] OWN_HK   = 2'b10;
  localparam logic [1:0] OWN_GAP  = 2'b11;
endpackage

// File: rtl/flash_bus_arbiter.sv
// flash_bus_arbiter: shares one SPI flash between the SoC controller and housekeeping pass-thru
module flash_bus_arbiter
  import flash_arb_pkg::*;
#(
  parameter int GAP_CYCLES = 4
) (
  input  logic       clk_osc,
  input  logic       FPGA_rst,
  input  logic       soc_req,
  input  logic       soc_csb,
  input  logic       soc_sck,
  input  logic       soc_mosi,
  output logic       soc_gnt,
  output logic       soc_miso,
  input  logic       hk_req,
  input  logic       hk_csb,
  input  logic       hk_sck,
  input  logic       hk_mosi,
  output logic       hk_gnt,
  output logic       hk_miso,
  output logic       flash_csb,
  output logic       flash_clk,
  output logic       flash_io0,
  input  logic       flash_io1,
  output logic [1:0] owner
);
  localparam int CW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          w_soc_rel;
  logic          w_hk_rel;
  logic          w_soc;
  logic          w_hk;
  // an owner only lets go between transactions (its csb high)
  assign w_soc_rel = soc_csb & (~soc_req | hk_req);
  assign w_hk_rel  = hk_csb & ~hk_req;
  assign w_soc     = r_state == ST_SOC;
  assign w_hk      = r_state == ST_HK;
  // arbitration, release and inter-ownership gap timing
  always_ff @(posedge clk_osc or posedge FPGA_rst) begin
    if (FPGA_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= hk_req ? ST_HK : soc_req ? ST_SOC : ST_IDLE;
        ST_SOC: if (w_soc_rel) begin
          r_state <= ST_GAP;
          r_cnt   <= CW'(GAP_CYCLES);
        end
        ST_HK: if (w_hk_rel) begin
          r_state <= ST_GAP;
          r_cnt   <= CW'(GAP_CYCLES);
        end
        default: if (r_cnt <= CW'(1)) begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      endcase
    end
  end
  assign soc_gnt   = w_soc;
  assign hk_gnt    = w_hk;
  assign owner     = r_state;
  assign flash_csb = w_soc ? soc_csb : w_hk ? hk_csb : 1'b1;
  assign flash_clk = w_soc ? soc_sck : w_hk ? hk_sck : 1'b0;
  assign flash_io0 = w_soc ? soc_mosi : w_hk ? hk_mosi : 1'b0;
  assign soc_miso  = w_soc & flash_io1;
  assign hk_miso   = w_hk & flash_io1;
endmodule

// File: tb/tb_flash_bus_arbiter.sv
// tb_flash_bus_arbiter: directed scenarios plus random traffic against a timestamp-based ownership model
module tb_flash_bus_arbiter;
  logic clk = 0, rst = 1;
  logic soc_req = 0, soc_csb = 1, soc_sck = 0, soc_mosi = 0;
  logic hk_req = 0, hk_csb = 1, hk_sck = 0, hk_mosi = 0, io1 = 0;
  logic [1:0] own[2];
  logic sg[2], hg[2], sm[2], hm[2], fcsb[2], fclk[2], fio0[2];
  int total = 0, bad = 0, ecnt = 0;
  int m_own[2];
  int m_rel[2];
  int gapn[2] = '{4, 1};

  flash_bus_arbiter #(.GAP_CYCLES(4)) u0 (
    .clk_osc(clk), .FPGA_rst(rst),
    .soc_req(soc_req), .soc_csb(soc_csb), .soc_sck(soc_sck), .soc_mosi(soc_mosi),
    .soc_gnt(sg[0]), .soc_miso(sm[0]),
    .hk_req(hk_req), .hk_csb(hk_csb), .hk_sck(hk_sck), .hk_mosi(hk_mosi),
    .hk_gnt(hg[0]), .hk_miso(hm[0]),
    .flash_csb(fcsb[0]), .flash_clk(fclk[0]), .flash_io0(fio0[0]), .flash_io1(io1),
    .owner(own[0])
  );
  flash_bus_arbiter #(.GAP_CYCLES(0)) u1 (
    .clk_osc(clk), .FPGA_rst(rst),
    .soc_req(soc_req), .soc_csb(soc_csb), .soc_sck(soc_sck), .soc_mosi(soc_mosi),
    .soc_gnt(sg[1]), .soc_miso(sm[1]),
    .hk_req(hk_req), .hk_csb(hk_csb), .hk_sck(hk_sck), .hk_mosi(hk_mosi),
    .hk_gnt(hg[1]), .hk_miso(hm[1]),
    .flash_csb(fcsb[1]), .flash_clk(fclk[1]), .flash_io0(fio0[1]), .flash_io1(io1),
    .owner(own[1])
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [15:0] got, logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  // model: owner 0 none, 1 soc, 2 hk; release edge timestamp decides gap vs idle
  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      m_own[i] = 0;
      m_rel[i] = -1000;
    end
  endtask

  task automatic mstep();
    ecnt++;
    for (int i = 0; i < 2; i++) begin
      if (m_own[i] == 1) begin
        if (soc_csb && (!soc_req || hk_req)) begin m_own[i] = 0; m_rel[i] = ecnt; end
      end else if (m_own[i] == 2) begin
        if (hk_csb && !hk_req) begin m_own[i] = 0; m_rel[i] = ecnt; end
      end else if (ecnt - m_rel[i] > gapn[i]) begin
        m_own[i] = hk_req ? 2 : soc_req ? 1 : 0;
      end
    end
  endtask

  function automatic logic [8:0] expv(int i);
    logic [1:0] o;
    logic c, k, d;
    o = m_own[i] == 1 ? 2'b01 : m_own[i] == 2 ? 2'b10 : (ecnt - m_rel[i] < gapn[i]) ? 2'b11 : 2'b00;
    c = m_own[i] == 1 ? soc_csb : m_own[i] == 2 ? hk_csb : 1'b1;
    k = m_own[i] == 1 ? soc_sck : m_own[i] == 2 ? hk_sck : 1'b0;
    d = m_own[i] == 1 ? soc_mosi : m_own[i] == 2 ? hk_mosi : 1'b0;
    return {o, m_own[i] == 1, m_own[i] == 2, c, k, d, m_own[i] == 1 && io1, m_own[i] == 2 && io1};
  endfunction

  function automatic logic [8:0] gotv(int i);
    return {own[i], sg[i], hg[i], fcsb[i], fclk[i], fio0[i], sm[i], hm[i]};
  endfunction

  task automatic cyc();
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk($sformatf("model_u%0d", i), 16'(gotv(i)), 16'(expv(i)));
    @(posedge clk);
    mstep();
    #1;
  endtask

  initial begin
    logic [31:0] cmd;
    logic [7:0] pat, rd;
    int k;
    cmd = 32'h03000000;
    pat = 8'h6f;
    rd = '0;
    mreset();
    repeat (2) @(negedge clk);
    chk("rst_owner", 16'(own[0]), 16'h0);
    chk("rst_csb", 16'(fcsb[0]), 16'h1);
    chk("rst_gnt", 16'({sg[0], hg[0], fclk[0], fio0[0]}), 16'h0);
    @(posedge clk);
    #1 rst = 0;
    repeat (3) cyc();
    // HK read of one byte from a flash returning 0x6f
    hk_req = 1;
    cyc();
    chk("hk_gnt_lat", 16'(hg[0]), 16'h1);
    chk("hk_owner", 16'(own[0]), 16'h2);
    hk_csb = 0;
    for (int b = 0; b < 40; b++) begin
      hk_sck = 0;
      hk_mosi = b < 32 ? cmd[31-b] : 1'b0;
      io1 = b >= 32 ? pat[39-b] : 1'b0;
      #1 rd = b >= 32 ? {rd[6:0], hm[0]} : rd;
      cyc();
      hk_sck = 1;
      cyc();
    end
    chk("hk_read_byte", 16'(rd), 16'h6f);
    hk_sck = 0;
    io1 = 0;
    hk_csb = 1;
    hk_req = 0;
    repeat (8) cyc();
    // simultaneous requests: HK wins, SoC after gap
    hk_req = 1;
    soc_req = 1;
    cyc();
    chk("sim_hk_gnt", 16'(hg[0]), 16'h1);
    chk("sim_soc_gnt", 16'(sg[0]), 16'h0);
    hk_req = 0;
    cyc();
    chk("rel_gap0", 16'({own[0], own[1]}), 16'hf);
    cyc();
    chk("gap1", 16'({own[0], own[1]}), 16'hc);
    cyc();
    chk("gap2", 16'({own[0], own[1]}), 16'hd);
    chk("g0_soc_gnt", 16'(sg[1]), 16'h1);
    cyc();
    chk("gap3", 16'(own[0]), 16'h3);
    cyc();
    chk("gap_idle", 16'(own[0]), 16'h0);
    cyc();
    chk("soc_after_gap", 16'({own[0], sg[0]}), 16'h3);
    // HK request during a SoC read is held off until soc_csb rises
    soc_csb = 0;
    for (int c = 0; c < 16; c++) begin
      soc_sck = c[0];
      soc_mosi = 1'($urandom);
      io1 = 1'($urandom);
      if (c == 4) hk_req = 1;
      cyc();
      chk("soc_hold", 16'({sg[0], fcsb[0]}), 16'h2);
    end
    soc_sck = 0;
    soc_csb = 1;
    cyc();
    chk("preempt_gap", 16'({own[0], sg[0]}), 16'h6);
    k = 0;
    while (!hg[0] && k < 10) begin
      cyc();
      k++;
    end
    chk("hk_after_preempt", 16'(k), 16'd5);
    // HK drops req mid-transaction while SoC waits
    hk_csb = 0;
    hk_req = 0;
    for (int c = 0; c < 6; c++) begin
      hk_sck = c[0];
      hk_mosi = 1'($urandom);
      soc_sck = ~c[0];
      soc_mosi = 1'($urandom);
      #1;
      chk("hk_hold", 16'({hg[0], sg[0]}), 16'h2);
      chk("hk_pins", 16'(fio0[0]), 16'(hk_mosi));
      cyc();
    end
    hk_sck = 0;
    hk_csb = 1;
    cyc();
    chk("hk_rel_gap", 16'(own[0]), 16'h3);
    soc_req = 0;
    repeat (6) cyc();
    // asynchronous reset in the middle of an HK transfer
    hk_req = 1;
    repeat (2) cyc();
    hk_csb = 0;
    repeat (3) cyc();
    #2 rst = 1;
    mreset();
    #1;
    chk("arst_csb", 16'({fcsb[0], fcsb[1]}), 16'h3);
    chk("arst_gnt", 16'({hg[0], sg[0], own[0]}), 16'h0);
    rst = 0;
    hk_csb = 1;
    cyc();
    chk("post_rst_hk", 16'(hg[0]), 16'h1);
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      soc_req ^= $urandom_range(11) == 0;
      hk_req ^= $urandom_range(15) == 0;
      soc_csb ^= $urandom_range(3) == 0;
      hk_csb ^= $urandom_range(3) == 0;
      soc_sck = 1'($urandom);
      hk_sck = 1'($urandom);
      soc_mosi = 1'($urandom);
      hk_mosi = 1'($urandom);
      io1 = 1'($urandom);
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
